// File: rtl/cv32e40p_tmr_pkg.sv
// Shared types for the TMR fault manager: FSM states, replica index, voter select mapping.
package cv32e40p_tmr_pkg;

  typedef enum logic [1:0] {
    TMR  = 2'd0,
    DMR  = 2'd1,
    FAIL = 2'd2
  } fm_state_e;

  // Replica index 1..3; 0 means "none".
  typedef logic [1:0] replica_t;

  typedef struct packed {
    replica_t sel_a;
    replica_t sel_b;
  } sel_pair_t;

  // Route the two surviving replicas to voter inputs 1 and 2, lowest index first.
  function automatic sel_pair_t sel_map(replica_t excl);
    sel_pair_t p;
    case (excl)
      2'd1:    begin p.sel_a = 2'd2; p.sel_b = 2'd3; end
      2'd2:    begin p.sel_a = 2'd1; p.sel_b = 2'd3; end
      default: begin p.sel_a = 2'd1; p.sel_b = 2'd2; end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/cv32e40p_tmr_fault_manager_if.sv
// Voter <-> fault manager link: per-replica error flags in, replica routing out.
interface cv32e40p_tmr_fault_manager_if;
  import cv32e40p_tmr_pkg::*;

  logic     err_valid_i;
  logic     err_detected_1_i;
  logic     err_detected_2_i;
  logic     err_detected_3_i;
  logic     err_corrected_i;
  logic     only_two_o;
  replica_t sel_a_o;
  replica_t sel_b_o;

  // Voter side: produces flags, consumes routing.
  modport master (
    output err_valid_i, err_detected_1_i, err_detected_2_i, err_detected_3_i, err_corrected_i,
    input  only_two_o, sel_a_o, sel_b_o
  );

  // Fault manager side.
  modport slave (
    input  err_valid_i, err_detected_1_i, err_detected_2_i, err_detected_3_i, err_corrected_i,
    output only_two_o, sel_a_o, sel_b_o
  );
endinterface

// File: rtl/cv32e40p_tmr_err_counter.sv
// Saturating up/down per-replica error counter with clear (highest priority) and freeze.
module cv32e40p_tmr_err_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         frz_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d, cnt_q;

  // Next count: clear, else hold when frozen, else saturating increment or floor-at-zero decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!frz_i) begin
      if (inc_i) begin
        if (cnt_q != '1) cnt_d = cnt_q + W'(1);
      end else if (dec_i && (cnt_q != '0)) begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40p_tmr_fault_manager.sv
// Per-stage TMR fault manager: leaky per-replica error counters, TMR->DMR->FAIL degradation.
module cv32e40p_tmr_fault_manager
  import cv32e40p_tmr_pkg::*;
#(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned PERM_THRESH  = 4,
  parameter int unsigned DECAY_PERIOD = 1024,
  parameter int unsigned CORR_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cv32e40p_tmr_fault_manager_if.slave   vif,
  input  logic                          clear_i,
  output replica_t                      excluded_o,
  output logic [1:0]                    state_o,
  output logic                          fatal_o,
  output logic                          irq_o,
  output logic [3*CNT_W-1:0]            err_cnt_o,
  output logic [CORR_W-1:0]             corr_cnt_o
);

  localparam int unsigned DECAY_W = (DECAY_PERIOD > 2) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_PERIOD - 1);
  localparam logic [CNT_W-1:0]   THRESH_PRE = CNT_W'(PERM_THRESH - 1);

  fm_state_e            state_d, state_q;
  replica_t             excl_d, excl_q;
  logic                 only_two_d, only_two_q;
  replica_t             sel_a_d, sel_a_q;
  replica_t             sel_b_d, sel_b_q;
  logic                 fatal_d, fatal_q;
  logic                 irq_d, irq_q;
  logic [DECAY_W-1:0]   decay_d, decay_q;
  logic [CORR_W-1:0]    corr_d, corr_q;

  logic [2:0]           flags_c;
  logic [2:0]           inc_c;
  logic                 dec_c;
  logic [2:0]           thresh_hit_c;
  replica_t             flag_idx_c;
  sel_pair_t            sel_c;
  logic [CNT_W-1:0]     cnt [3];

  assign flags_c = {vif.err_detected_3_i, vif.err_detected_2_i, vif.err_detected_1_i};

  // Three replica counters; frozen outside TMR, cleared by software clear.
  for (genvar i = 0; i < 3; i++) begin : g_cnt
    cv32e40p_tmr_err_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (clear_i),
      .frz_i (state_q != TMR),
      .inc_i (inc_c[i]),
      .dec_i (dec_c),
      .cnt_o (cnt[i])
    );
    // One more error on this replica reaches the permanent-fault threshold.
    assign thresh_hit_c[i] = (cnt[i] >= THRESH_PRE);
  end

  // Replica index of a single set flag, and routing once it is excluded.
  always_comb begin
    flag_idx_c = 2'd3;
    if (flags_c[0])      flag_idx_c = 2'd1;
    else if (flags_c[1]) flag_idx_c = 2'd2;
    sel_c = sel_map(flag_idx_c);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    excl_d     = excl_q;
    only_two_d = only_two_q;
    sel_a_d    = sel_a_q;
    sel_b_d    = sel_b_q;
    decay_d    = decay_q;
    corr_d     = corr_q;
    inc_c      = 3'b000;
    dec_c      = 1'b0;

    if (clear_i) begin
      state_d    = TMR;
      excl_d     = 2'd0;
      only_two_d = 1'b0;
      sel_a_d    = 2'd1;
      sel_b_d    = 2'd2;
      decay_d    = '0;
      corr_d     = '0;
    end else begin
      case (state_q)
        TMR: begin
          if (vif.err_valid_i && (flags_c != 3'b000)) begin
            decay_d = '0;
            case (flags_c)
              3'b001, 3'b010, 3'b100: begin
                inc_c = flags_c;
                if ((flags_c & thresh_hit_c) != 3'b000) begin
                  state_d    = DMR;
                  excl_d     = flag_idx_c;
                  only_two_d = 1'b1;
                  sel_a_d    = sel_c.sel_a;
                  sel_b_d    = sel_c.sel_b;
                end
              end
              default: state_d = FAIL;
            endcase
          end else if (decay_q == DECAY_LAST) begin
            dec_c   = 1'b1;
            decay_d = '0;
          end else begin
            decay_d = decay_q + DECAY_W'(1);
          end
          if (vif.err_valid_i && vif.err_corrected_i && (corr_q != '1)) begin
            corr_d = corr_q + CORR_W'(1);
          end
        end
        DMR: begin
          if (vif.err_valid_i && (vif.err_detected_1_i || vif.err_detected_2_i)) state_d = FAIL;
        end
        FAIL: ;
        default: state_d = TMR;
      endcase
    end

    fatal_d = (state_d == FAIL);
    irq_d   = (state_d != state_q) && (state_d != TMR);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TMR;
      excl_q     <= 2'd0;
      only_two_q <= 1'b0;
      sel_a_q    <= 2'd1;
      sel_b_q    <= 2'd2;
      fatal_q    <= 1'b0;
      irq_q      <= 1'b0;
      decay_q    <= '0;
      corr_q     <= '0;
    end else begin
      state_q    <= state_d;
      excl_q     <= excl_d;
      only_two_q <= only_two_d;
      sel_a_q    <= sel_a_d;
      sel_b_q    <= sel_b_d;
      fatal_q    <= fatal_d;
      irq_q      <= irq_d;
      decay_q    <= decay_d;
      corr_q     <= corr_d;
    end
  end

  assign vif.only_two_o = only_two_q;
  assign vif.sel_a_o    = sel_a_q;
  assign vif.sel_b_o    = sel_b_q;
  assign excluded_o     = excl_q;
  assign state_o        = state_q;
  assign fatal_o        = fatal_q;
  assign irq_o          = irq_q;
  assign err_cnt_o      = {cnt[2], cnt[1], cnt[0]};
  assign corr_cnt_o     = corr_q;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
// Scoreboard bench for the TMR fault manager against a behavioural model of the degradation rules.
module tb_cv32e40p_tmr_fault_manager;
  import cv32e40p_tmr_pkg::*;

  localparam int CNT_W        = 8;
  localparam int PERM_THRESH  = 4;
  localparam int DECAY_PERIOD = 1024;
  localparam int CORR_W       = 16;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;
  localparam int CORR_MAX     = (1 << CORR_W) - 1;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 clear_i = 1'b0;
  replica_t             excluded_o;
  logic [1:0]           state_o;
  logic                 fatal_o;
  logic                 irq_o;
  logic [3*CNT_W-1:0]   err_cnt_o;
  logic [CORR_W-1:0]    corr_cnt_o;

  cv32e40p_tmr_fault_manager_if vif();

  cv32e40p_tmr_fault_manager #(
    .CNT_W(CNT_W), .PERM_THRESH(PERM_THRESH), .DECAY_PERIOD(DECAY_PERIOD), .CORR_W(CORR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vif        (vif),
    .clear_i    (clear_i),
    .excluded_o (excluded_o),
    .state_o    (state_o),
    .fatal_o    (fatal_o),
    .irq_o      (irq_o),
    .err_cnt_o  (err_cnt_o),
    .corr_cnt_o (corr_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int state; int excl; int only_two; int sel_a; int sel_b;
    int fatal; int irq; int cnt1; int cnt2; int cnt3; int corr;
  } exp_t;

  exp_t expq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model state.
  int m_state, m_excl, m_timer, m_corr, m_irq;
  int m_cnt [3];

  task automatic model_reset();
    m_state = 0; m_excl = 0; m_timer = 0; m_corr = 0; m_irq = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
  endtask

  task automatic model_step(input bit v, input bit f1, input bit f2, input bit f3,
                            input bit c, input bit clr);
    int prev, nf, r;
    prev = m_state;
    nf   = int'(f1) + int'(f2) + int'(f3);
    if (clr) begin
      m_state = 0; m_excl = 0; m_timer = 0; m_corr = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else if (m_state == 0) begin
      if (v && nf > 0) begin
        m_timer = 0;
        if (nf == 1) begin
          r = f1 ? 1 : (f2 ? 2 : 3);
          if (m_cnt[r-1] < CNT_MAX) m_cnt[r-1]++;
          if (m_cnt[r-1] >= PERM_THRESH) begin m_state = 1; m_excl = r; end
        end else begin
          m_state = 2;
        end
      end else if (m_timer == DECAY_PERIOD - 1) begin
        m_timer = 0;
        foreach (m_cnt[i]) if (m_cnt[i] > 0) m_cnt[i]--;
      end else begin
        m_timer++;
      end
      if (v && c && m_corr < CORR_MAX) m_corr++;
    end else if (m_state == 1) begin
      if (v && (f1 || f2)) m_state = 2;
    end
    m_irq = (m_state != prev && m_state != 0) ? 1 : 0;
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.state = m_state; e.excl = m_excl; e.irq = m_irq;
    e.fatal = (m_state == 2) ? 1 : 0;
    e.only_two = (m_excl != 0) ? 1 : 0;
    e.sel_a = 1; e.sel_b = 2;
    if (m_excl != 0) begin
      e.sel_a = 0;
      for (int r = 1; r <= 3; r++) begin
        if (r != m_excl) begin
          if (e.sel_a == 0) e.sel_a = r;
          else              e.sel_b = r;
        end
      end
    end
    e.cnt1 = m_cnt[0]; e.cnt2 = m_cnt[1]; e.cnt3 = m_cnt[2]; e.corr = m_corr;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // One clock of stimulus: drive at negedge, push the model's post-edge expectation.
  task automatic cycle(input bit v, input bit f1, input bit f2, input bit f3,
                       input bit c, input bit clr);
    @(negedge clk);
    rst_n = 1'b1;
    vif.err_valid_i      = v;
    vif.err_detected_1_i = f1;
    vif.err_detected_2_i = f2;
    vif.err_detected_3_i = f3;
    vif.err_corrected_i  = c;
    clear_i              = clr;
    model_step(v, f1, f2, f3, c, clr);
    expq.push_back(snapshot());
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted between clock edges; checked immediately.
  task automatic do_reset();
    @(negedge clk);
    #2;
    vif.err_valid_i = 1'b0; vif.err_detected_1_i = 1'b0; vif.err_detected_2_i = 1'b0;
    vif.err_detected_3_i = 1'b0; vif.err_corrected_i = 1'b0; clear_i = 1'b0;
    model_reset();
    expq.push_back(snapshot());
    rst_n = 1'b0;
  endtask

  // Monitor: compares every DUT update (clock edge or async reset) against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("state",    32'(state_o),              32'(e.state));
        chk("excluded", 32'(excluded_o),           32'(e.excl));
        chk("only_two", 32'(vif.only_two_o),       32'(e.only_two));
        chk("sel_a",    32'(vif.sel_a_o),          32'(e.sel_a));
        chk("sel_b",    32'(vif.sel_b_o),          32'(e.sel_b));
        chk("fatal",    32'(fatal_o),              32'(e.fatal));
        chk("irq",      32'(irq_o),                32'(e.irq));
        chk("err_cnt1", 32'(err_cnt_o[CNT_W-1:0]),         32'(e.cnt1));
        chk("err_cnt2", 32'(err_cnt_o[2*CNT_W-1:CNT_W]),   32'(e.cnt2));
        chk("err_cnt3", 32'(err_cnt_o[3*CNT_W-1:2*CNT_W]), 32'(e.cnt3));
        chk("corr_cnt", 32'(corr_cnt_o),           32'(e.corr));
      end
    end
  end

  initial begin
    bit v, f1, f2, f3, c, clr;
    int r, idx;
    vif.err_valid_i = 1'b0; vif.err_detected_1_i = 1'b0; vif.err_detected_2_i = 1'b0;
    vif.err_detected_3_i = 1'b0; vif.err_corrected_i = 1'b0;
    model_reset();

    do_reset();

    // Replica 2 accumulates errors until excluded.
    repeat (3) cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    idle(3);

    // Decay: single error leaks away exactly at expiry.
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0, 0);
    idle(DECAY_PERIOD + 2);

    // Error landing on the expiry cycle wins over the decrement.
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    idle(DECAY_PERIOD - 1);
    cycle(1, 1, 0, 0, 0, 0);
    idle(DECAY_PERIOD + 1);

    // No majority: all three flags, flags ignored in FAIL, clear recovers.
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 1, 0, 0);
    cycle(1, 1, 1, 1, 1, 0);
    cycle(1, 1, 0, 0, 1, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    // Two flags: illegal, also FAIL.
    cycle(1, 1, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);

    // DMR with replica 1 excluded: flag 3 ignored, pair mismatch fails.
    repeat (4) cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 1, 0);
    idle(2);
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);

    // Clear beats an error that would cross the threshold.
    repeat (3) cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 1);
    idle(2);

    // Replica 3 exclusion, then async reset mid-DMR.
    repeat (4) cycle(1, 0, 0, 1, 0, 0);
    idle(2);
    do_reset();
    idle(2);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      r   = int'($urandom_range(0, 99));
      v   = 1'($urandom_range(0, 1));
      c   = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 99) < 2);
      f1 = 1'b0; f2 = 1'b0; f3 = 1'b0;
      if (r < 25) begin
        idx = int'($urandom_range(1, 3));
        f1 = (idx == 1); f2 = (idx == 2); f3 = (idx == 3);
      end else if (r < 27) begin
        f1 = 1'($urandom_range(0, 1)); f2 = 1'b1; f3 = 1'($urandom_range(0, 1));
        if (!f1 && !f3) f3 = 1'b1;
      end
      cycle(v, f1, f2, f3, c, clr);
    end

    // Corrected-event counter saturation.
    cycle(0, 0, 0, 0, 0, 1);
    repeat (CORR_MAX + 1 + 5) cycle(1, 0, 0, 0, 1, 0);
    idle(2);

    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_tmr_fault_manager.md
Name: cv32e40p_tmr_fault_manager

Overview:
- Consumer side of the 3-way majority voter interface.
- Samples the voter's per-replica error flags and keeps per-replica leaky error counters.
- Drives the voter's only_two control and the replica-select mapping. A replica that crosses the permanent-fault threshold is excluded, and the core drops from TMR to DMR operation.
- Escalates to a fatal state when no correct majority or pair remains. One instance per voted pipeline stage.

Parameters:
CNT_W, 8, width of each per-replica error counter (saturating)
PERM_THRESH, 4, counter value at which a replica is declared permanently faulty (1..2^CNT_W-1)
DECAY_PERIOD, 1024, error-free TMR cycles between counter decrements (>=2)
CORR_W, 16, width of saturating corrected-error event counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
err_valid_i  in  1  voter flags valid this cycle
err_detected_1_i  in  1  voter flag, replica on voter input 1 disagrees
err_detected_2_i  in  1  voter flag, replica on voter input 2 disagrees
err_detected_3_i  in  1  voter flag, replica on voter input 3 disagrees (ignored in DMR)
err_corrected_i  in  1  voter produced a corrected majority
clear_i  in  1  software clear: counters to 0, return to TMR
only_two_o  out  1  to voter: compare inputs 1 and 2 only
sel_a_o  out  2  replica index (1..3) routed to voter input 1
sel_b_o  out  2  replica index (1..3) routed to voter input 2
excluded_o  out  2  excluded replica index, 0 = none
state_o  out  2  0 TMR, 1 DMR, 2 FAIL
fatal_o  out  1  level, high in FAIL
irq_o  out  1  one-cycle pulse on entry to DMR or FAIL
err_cnt_o  out  3*CNT_W  per-replica counters, replica 1 in LSBs
corr_cnt_o  out  CORR_W  saturating count of err_corrected_i events

Behaviour:
- Reset values (async, rst_n low):
  - state TMR; all counters 0; decay timer 0
  - only_two_o=0, sel_a_o=1, sel_b_o=2, excluded_o=0
  - fatal_o=0, irq_o=0
- All outputs are registered. The effect of a sampled flag is visible the cycle after err_valid_i.
- Flags are only acted on when err_valid_i=1.

TMR state:
- Exactly one detect flag set:
  - Increment that replica's counter (saturating).
  - If the post-increment value >= PERM_THRESH: go to DMR, excluded_o=that replica, irq_o pulse.
- All three flags set: no majority. Go to FAIL, irq_o pulse; counters not incremented.
- Two flags set: illegal combination, treated as no majority. Go to FAIL.
- err_corrected_i=1 with valid: corr_cnt_o increments, saturating at 2^CORR_W-1.
- Decay timer:
  - Counts cycles without a valid nonzero flag.
  - On reaching DECAY_PERIOD-1, decrement every nonzero err_cnt by 1 and restart from 0.
  - Any valid nonzero flag restarts the timer. If a flag and decay expiry land in the same cycle, the error wins and no decrement occurs.

DMR state:
- only_two_o=1; irq_o pulses on entry.
- Mapping:
  - excluded=1 → sel_a=2, sel_b=3
  - excluded=2 → sel_a=1, sel_b=3
  - excluded=3 → sel_a=1, sel_b=2
- err_detected_1_i or err_detected_2_i with valid: pair mismatch. Go to FAIL, irq_o pulse.
- err_detected_3_i is ignored.
- Counters and decay are frozen; corr_cnt_o is not updated.

FAIL state:
- fatal_o=1, only_two_o holds its previous value, mapping holds.
- All flags are ignored; only clear_i exits.

clear_i (any state):
- Next cycle: TMR, all err_cnt=0, decay timer 0, mapping and only_two_o back to reset values, fatal_o=0.
- corr_cnt_o is also cleared; no irq_o.
- clear_i takes priority over a simultaneous flag or decay event.

Other rules:
- An irq_o is never generated twice for the same state entry.
- FAIL→FAIL does not re-pulse.
- rst_n assertion mid-operation returns everything to reset values asynchronously.

Decomposition:
- Shared package cv32e40p_tmr_pkg:
  - fm_state_e enum (TMR=2'd0, DMR=2'd1, FAIL=2'd2)
  - replica index typedef (2-bit)
  - function mapping excluded index → {sel_a, sel_b}
- Natural sub-module: cv32e40p_tmr_err_counter, a saturating up/down counter with clear and freeze, instantiated three times.
- FSM, decay timer and corr counter stay in the top module.

Test Plan:
- Reset, then 3 valid cycles with only err_detected_2_i=1 → err_cnt_o[2]=3, state TMR. A 4th such cycle → next cycle state_o=1, excluded_o=2, sel_a_o=1, sel_b_o=3, only_two_o=1, single irq_o pulse.
- TMR, one flag-1 error, then DECAY_PERIOD error-free cycles → err_cnt_o[1] goes 1→0 exactly at expiry. A flag in the expiry cycle → no decrement, timer restarts.
- TMR, valid with all three flags=1 → FAIL, fatal_o=1, irq_o pulse, counters unchanged. Further flags ignored; clear_i → TMR, all counters 0, fatal_o=0.
- DMR with excluded=1, valid err_detected_3_i=1 alone → no change. Valid err_detected_1_i=err_detected_2_i=1 → FAIL.
- Same-cycle clear_i and err_detected_1_i with counter at PERM_THRESH-1 → TMR, counter 0, no DMR entry, no irq_o.
- err_corrected_i valid 2^CORR_W+5 times → corr_cnt_o saturates at 0xFFFF. Async rst_n pulse mid-DMR → immediate reset values.
